// File: rtl/async_sram_ctrl.sv
// Synchronous request/response front end for an asynchronous SRAM.
// Every SRAM strobe comes straight from a flop, so the strobes cannot glitch.
//
// state | meaning
// IDLE  | no access in progress, req_ready = 1, all strobes inactive
// RD    | n_cs/n_oe low, counting down the read access time
// WR_S  | address/data/n_cs valid, n_we still high (setup)
// WR_P  | n_we low (write pulse)
// WR_H  | n_we high again, address/data/n_cs held (hold)
module async_sram_ctrl #(
  parameter int D_WIDTH  = 8,
  parameter int A_WIDTH  = 15,
  parameter int RD_WAIT  = 3,
  parameter int WR_SETUP = 1,
  parameter int WR_PULSE = 3,
  parameter int WR_HOLD  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [A_WIDTH-1:0] req_addr,
  input  logic [D_WIDTH-1:0] req_wdata,
  output logic               rsp_done,
  output logic [D_WIDTH-1:0] rsp_rdata,
  output logic [A_WIDTH-1:0] mem_a,
  output logic [D_WIDTH-1:0] mem_d_out,
  output logic               mem_d_drive,
  input  logic [D_WIDTH-1:0] mem_d_in,
  output logic               mem_n_cs,
  output logic               mem_n_oe,
  output logic               mem_n_we
);

  localparam int T_MAX_RW = (RD_WAIT > WR_SETUP) ? RD_WAIT : WR_SETUP;
  localparam int T_MAX_PH = (WR_PULSE > WR_HOLD) ? WR_PULSE : WR_HOLD;
  localparam int T_MAX    = (T_MAX_RW > T_MAX_PH) ? T_MAX_RW : T_MAX_PH;
  localparam int C_WIDTH  = $clog2(T_MAX) + 1;

  localparam logic [C_WIDTH-1:0] RD_LD  = C_WIDTH'(RD_WAIT);
  localparam logic [C_WIDTH-1:0] WS_LD  = C_WIDTH'(WR_SETUP);
  localparam logic [C_WIDTH-1:0] WP_LD  = C_WIDTH'(WR_PULSE);
  localparam logic [C_WIDTH-1:0] WH_LD  = C_WIDTH'(WR_HOLD);
  localparam logic [C_WIDTH-1:0] CNT_TC = C_WIDTH'(1);

  // A zero-cycle phase would make the down-counter skip its terminal count.
  if (RD_WAIT < 1) begin : g_bad_rd_wait
    $error("async_sram_ctrl: RD_WAIT must be >= 1");
  end
  if (WR_SETUP < 1) begin : g_bad_wr_setup
    $error("async_sram_ctrl: WR_SETUP must be >= 1");
  end
  if (WR_PULSE < 1) begin : g_bad_wr_pulse
    $error("async_sram_ctrl: WR_PULSE must be >= 1");
  end
  if (WR_HOLD < 1) begin : g_bad_wr_hold
    $error("async_sram_ctrl: WR_HOLD must be >= 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR_S,
    WR_P,
    WR_H
  } state_t;

  state_t             state, state_nxt;
  logic [C_WIDTH-1:0] cnt, cnt_nxt;
  logic               cnt_last;
  logic               accept;
  logic               rd_capture;
  logic               done_nxt;
  logic               n_cs_nxt, n_oe_nxt, n_we_nxt, drive_nxt;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;
  assign cnt_last  = (cnt == CNT_TC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      mem_n_cs    <= 1'b1;
      mem_n_oe    <= 1'b1;
      mem_n_we    <= 1'b1;
      mem_d_drive <= 1'b0;
      mem_a       <= '0;
      mem_d_out   <= '0;
      rsp_rdata   <= '0;
      rsp_done    <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      mem_n_cs    <= n_cs_nxt;
      mem_n_oe    <= n_oe_nxt;
      mem_n_we    <= n_we_nxt;
      mem_d_drive <= drive_nxt;
      rsp_done    <= done_nxt;
      // Address and data only move on acceptance, so they stay put for the whole access.
      if (accept) begin
        mem_a     <= req_addr;
        mem_d_out <= req_wdata;
      end
      if (rd_capture) begin
        rsp_rdata <= mem_d_in;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    done_nxt   = 1'b0;
    rd_capture = 1'b0;

    case (state)
      IDLE: begin
        if (req_valid) begin
          state_nxt = req_we ? WR_S : RD;
          cnt_nxt   = req_we ? WS_LD : RD_LD;
        end
      end
      RD: begin
        if (cnt_last) begin
          state_nxt  = IDLE;
          cnt_nxt    = '0;
          done_nxt   = 1'b1;
          rd_capture = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_TC;
        end
      end
      WR_S: begin
        if (cnt_last) begin
          state_nxt = WR_P;
          cnt_nxt   = WP_LD;
        end else begin
          cnt_nxt = cnt - CNT_TC;
        end
      end
      WR_P: begin
        if (cnt_last) begin
          state_nxt = WR_H;
          cnt_nxt   = WH_LD;
        end else begin
          cnt_nxt = cnt - CNT_TC;
        end
      end
      WR_H: begin
        if (cnt_last) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_TC;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // Strobes are decoded from the next state and registered, so they line up with the state.
    n_cs_nxt  = (state_nxt == IDLE);
    n_oe_nxt  = (state_nxt != RD);
    n_we_nxt  = (state_nxt != WR_P);
    drive_nxt = (state_nxt == WR_S) || (state_nxt == WR_P) || (state_nxt == WR_H);
  end

endmodule

// File: tb/tb_async_sram_ctrl.sv
// Bench for async_sram_ctrl: a default instance and a 16-bit/17-bit instance with different timing,
// each attached to a behavioural SRAM and checked every cycle against a timeline model.
module tb_async_sram_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  logic        req_valid [2];
  logic        req_we    [2];
  logic [16:0] req_addr  [2];
  logic [15:0] req_wdata [2];

  logic        rdy0, done0, ncs0, noe0, nwe0, drv0;
  logic [14:0] a0;
  logic [7:0]  dout0, rdat0, din0;
  logic        rdy1, done1, ncs1, noe1, nwe1, drv1;
  logic [16:0] a1;
  logic [15:0] dout1, rdat1, din1;

  async_sram_ctrl u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(rdy0), .req_we(req_we[0]),
    .req_addr(req_addr[0][14:0]), .req_wdata(req_wdata[0][7:0]),
    .rsp_done(done0), .rsp_rdata(rdat0),
    .mem_a(a0), .mem_d_out(dout0), .mem_d_drive(drv0), .mem_d_in(din0),
    .mem_n_cs(ncs0), .mem_n_oe(noe0), .mem_n_we(nwe0)
  );

  async_sram_ctrl #(
    .D_WIDTH(16), .A_WIDTH(17), .RD_WAIT(1), .WR_SETUP(2), .WR_PULSE(1), .WR_HOLD(2)
  ) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(rdy1), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_done(done1), .rsp_rdata(rdat1),
    .mem_a(a1), .mem_d_out(dout1), .mem_d_drive(drv1), .mem_d_in(din1),
    .mem_n_cs(ncs1), .mem_n_oe(noe1), .mem_n_we(nwe1)
  );

  // Behavioural asynchronous SRAMs
  logic [7:0]  sram0 [32768];
  logic [15:0] sram1 [131072];
  assign din0 = (!ncs0 && !noe0) ? sram0[a0] : 8'h00;
  assign din1 = (!ncs1 && !noe1) ? sram1[a1] : 16'h0000;
  always @(posedge clk) begin
    if (!ncs0 && !nwe0 && drv0) sram0[a0] <= dout0;
    if (!ncs1 && !nwe1 && drv1) sram1[a1] <= dout1;
  end

  logic        rdy [2], dn [2], cs_b [2], oe_b [2], we_b [2], drv [2];
  logic [16:0] ma [2];
  logic [15:0] md [2], rd [2];
  always_comb begin
    rdy[0] = rdy0; dn[0] = done0; cs_b[0] = ncs0; oe_b[0] = noe0; we_b[0] = nwe0; drv[0] = drv0;
    ma[0] = {2'b00, a0}; md[0] = {8'h00, dout0}; rd[0] = {8'h00, rdat0};
    rdy[1] = rdy1; dn[1] = done1; cs_b[1] = ncs1; oe_b[1] = noe1; we_b[1] = nwe1; drv[1] = drv1;
    ma[1] = a1; md[1] = dout1; rd[1] = rdat1;
  end

  function automatic int f_rd(input int i); return (i == 0) ? 3 : 1; endfunction
  function automatic int f_ws(input int i); return (i == 0) ? 1 : 2; endfunction
  function automatic int f_wp(input int i); return (i == 0) ? 3 : 1; endfunction
  function automatic int f_wh(input int i); return (i == 0) ? 1 : 2; endfunction
  function automatic logic [16:0] f_amask(input int i); return (i == 0) ? 17'h07FFF : 17'h1FFFF; endfunction
  function automatic logic [15:0] f_dmask(input int i); return (i == 0) ? 16'h00FF : 16'hFFFF; endfunction

  function automatic void chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] got %0h expected %0h at %0t", nm, i, act, exp, $time);
    end
  endfunction

  // Model: an access is a timeline of cycles k = 1..lat after the accept edge, then one done cycle.
  bit          m_busy [2], m_wr [2], m_done [2];
  int          m_k [2], m_lat [2];
  logic [16:0] m_a [2];
  logic [15:0] m_d [2], m_rdata [2];
  logic [15:0] ref_mem [2][131072];

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_busy[i] <= 1'b0; m_wr[i] <= 1'b0; m_done[i] <= 1'b0;
        m_k[i] <= 0; m_lat[i] <= 0;
        m_a[i] <= '0; m_d[i] <= '0; m_rdata[i] <= '0;
      end else if (m_busy[i]) begin
        if (m_k[i] >= m_lat[i]) begin
          m_busy[i] <= 1'b0;
          m_done[i] <= 1'b1;
          if (m_wr[i]) ref_mem[i][m_a[i]] <= m_d[i];
          else         m_rdata[i] <= ref_mem[i][m_a[i]];
        end else begin
          m_k[i] <= m_k[i] + 1;
        end
      end else begin
        m_done[i] <= 1'b0;
        if (req_valid[i]) begin
          m_busy[i] <= 1'b1;
          m_k[i]    <= 1;
          m_wr[i]   <= req_we[i];
          m_a[i]    <= req_addr[i] & f_amask(i);
          m_d[i]    <= req_wdata[i] & f_dmask(i);
          m_lat[i]  <= req_we[i] ? (f_ws(i) + f_wp(i) + f_wh(i)) : f_rd(i);
        end
      end
    end
  end

  always @(negedge clk) begin
    int  s, p;
    bit  pulse;
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        s = f_ws(i);
        p = f_wp(i);
        pulse = m_busy[i] && m_wr[i] && (m_k[i] > s) && (m_k[i] <= s + p);
        chk("req_ready", i, 32'(rdy[i]), 32'(!m_busy[i]));
        chk("rsp_done",  i, 32'(dn[i]),  32'(m_done[i]));
        chk("mem_n_cs",  i, 32'(cs_b[i]), 32'(!m_busy[i]));
        chk("mem_n_oe",  i, 32'(oe_b[i]), 32'(!(m_busy[i] && !m_wr[i])));
        chk("mem_n_we",  i, 32'(we_b[i]), 32'(!pulse));
        chk("mem_d_drive", i, 32'(drv[i]), 32'(m_busy[i] && m_wr[i]));
        chk("mem_a",     i, 32'(ma[i]), 32'(m_a[i]));
        chk("mem_d_out", i, 32'(md[i]), 32'(m_d[i]));
        chk("rsp_rdata", i, 32'(rd[i]), 32'(m_rdata[i]));
        chk("inv_oe_and_drive", i, 32'(!oe_b[i] && drv[i]), 32'd0);
        chk("inv_we_and_oe",    i, 32'(!we_b[i] && !oe_b[i]), 32'd0);
        chk("inv_strobe_wo_cs", i, 32'((!oe_b[i] || !we_b[i]) && cs_b[i]), 32'd0);
      end
    end
  end

  task automatic wait_accept(input int i, output bit ok);
    bit r;
    ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      r = rdy[i];
      @(posedge clk);
      #2;
      if (r) ok = 1'b1;
    end
    chk("accept", i, 32'(ok), 32'd1);
  endtask

  task automatic access(input int i, input bit we, input logic [16:0] a, input logic [15:0] d,
                        input bit jitter, output int lat, output int we_cnt, output int drv_cnt,
                        output int first_we, output logic [15:0] rdv);
    bit ok;
    lat = -1; we_cnt = 0; drv_cnt = 0; first_we = -1; rdv = '0;
    req_we[i] = we; req_addr[i] = a; req_wdata[i] = d; req_valid[i] = 1'b1;
    wait_accept(i, ok);
    req_valid[i] = 1'b0;
    for (int j = 1; j <= 50 && ok && lat < 0; j++) begin
      @(negedge clk);
      if (!we_b[i]) begin
        we_cnt++;
        if (first_we < 0) first_we = j;
      end
      if (drv[i]) drv_cnt++;
      if (dn[i]) begin
        lat = j - 1;
        rdv = rd[i];
      end else if (jitter) begin
        #1;
        req_addr[i]  = ~req_addr[i];
        req_wdata[i] = req_wdata[i] + 16'h0101;
      end
    end
  endtask

  initial begin
    int          lat, wec, drc, fwe, cnt, idx, win, cshi, ndone;
    bit          ok, r, started;
    logic [15:0] rdv;

    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = '0; req_wdata[i] = '0;
    end
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_ready", 0, 32'(rdy0), 32'd1);
    chk("reset_ncs",   0, 32'(ncs0), 32'd1);
    chk("reset_rdata", 0, 32'(rdat0), 32'd0);
    chk("reset_addr",  1, 32'(a1), 32'd0);

    // Inputs wiggle but req_valid stays low: no strobe may move.
    cnt = 0;
    for (int n = 0; n < 10; n++) begin
      req_addr[0] = 17'(n * 37); req_wdata[0] = 16'(n); req_we[0] = n[0];
      @(negedge clk);
      if (!ncs0 || !noe0 || !nwe0 || drv0) cnt++;
    end
    chk("idle_activity", 0, cnt, 0);

    // Reset in the middle of the write pulse.
    req_we[0] = 1'b1; req_addr[0] = 17'h00777; req_wdata[0] = 16'h0099; req_valid[0] = 1'b1;
    wait_accept(0, ok);
    req_valid[0] = 1'b0;
    @(posedge clk);
    #2;
    chk("abort_pulse_nwe", 0, 32'(nwe0), 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("abort_nwe",   0, 32'(nwe0), 32'd1);
    chk("abort_ncs",   0, 32'(ncs0), 32'd1);
    chk("abort_drive", 0, 32'(drv0), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    cnt = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (done0) cnt++;
    end
    chk("abort_no_done", 0, cnt, 0);
    chk("abort_ready",   0, 32'(rdy0), 32'd1);

    access(0, 1'b1, 17'h01234, 16'h00A5, 1'b0, lat, wec, drc, fwe, rdv);
    chk("wr_latency",   0, lat, 5);
    chk("wr_nwe_cycles", 0, wec, 3);
    chk("wr_nwe_first", 0, fwe, 2);
    chk("wr_drive_cycles", 0, drc, 5);
    access(0, 1'b0, 17'h01234, 16'h0000, 1'b0, lat, wec, drc, fwe, rdv);
    chk("rd_latency", 0, lat, 3);
    chk("rd_data",    0, 32'(rdv), 32'h000000A5);

    // Back-to-back: write 0x11, read, write 0x22, read, with req_valid held high.
    idx = 0; started = 1'b0; win = 0; cshi = 0; ndone = 0;
    req_we[0] = 1'b1; req_addr[0] = 17'h00100; req_wdata[0] = 16'h0011; req_valid[0] = 1'b1;
    for (int n = 0; n < 100 && ndone < 4; n++) begin
      @(negedge clk);
      r = rdy0;
      if (started) begin
        win++;
        if (ncs0) cshi++;
        if (done0) begin
          ndone++;
          if (ndone == 2) chk("b2b_rd1", 0, 32'(rdat0), 32'h00000011);
          if (ndone == 4) chk("b2b_rd2", 0, 32'(rdat0), 32'h00000022);
        end
      end
      if (ndone < 4) begin
        @(posedge clk);
        #2;
        if (r && req_valid[0]) begin
          started = 1'b1;
          idx++;
          case (idx)
            1: req_we[0] = 1'b0;
            2: begin req_we[0] = 1'b1; req_wdata[0] = 16'h0022; end
            3: req_we[0] = 1'b0;
            default: req_valid[0] = 1'b0;
          endcase
        end
      end
    end
    req_valid[0] = 1'b0;
    chk("b2b_done_count", 0, ndone, 4);
    chk("b2b_ncs_high",   0, cshi, 4);
    chk("b2b_window",     0, win, 20);

    // Request inputs change every cycle while the controller is busy.
    access(0, 1'b1, 17'h00055, 16'h003C, 1'b1, lat, wec, drc, fwe, rdv);
    chk("stable_latency", 0, lat, 5);
    chk("stable_addr",    0, 32'(a0), 32'h00000055);
    chk("stable_data",    0, 32'(dout0), 32'h0000003C);

    access(1, 1'b1, 17'h1FFFF, 16'hBEEF, 1'b0, lat, wec, drc, fwe, rdv);
    chk("p_wr_latency",  1, lat, 5);
    chk("p_wr_nwe_cycles", 1, wec, 1);
    chk("p_wr_nwe_first", 1, fwe, 3);
    chk("p_wr_drive_cycles", 1, drc, 5);
    access(1, 1'b0, 17'h1FFFF, 16'h0000, 1'b0, lat, wec, drc, fwe, rdv);
    chk("p_rd_latency", 1, lat, 1);
    chk("p_rd_data",    1, 32'(rdv), 32'h0000BEEF);

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
